patt_gen: RTL and testbench

//   Serial pattern transmitter: the stimulus side of the serial sequence detectors.
//   On a start request it latches a W-bit pattern and a repeat count, then drives the pattern
//   MSB-first on x, one bit per clock, back-to-back for the requested number of repetitions.
//   x feeds a detector's serial input directly; vld/busy/done frame the transmission.

---
 rtl/patt_pkg.sv | 31 +++
 rtl/patt_gen_if.sv | 28 ++
 rtl/patt_shreg.sv | 37 +++
 rtl/patt_gen.sv | 150 +++++++++++++++
 tb/tb_patt_gen.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/patt_pkg.sv
// patt_pkg: definitions shared by the pattern transmitter and the detector benches.
//   - 2-bit state encodings (ST_IDLE/ST_SEND/ST_FIN) and the matching state_t enum
//   - PATT_1011: default pattern constant for the 1011 detector
//   - PAR_BITS: extra bits per repetition (1 when `PATT_GEN_PARITY_EN is defined)
//   - even_parity(): parity helper for the optional parity cycle
package patt_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    SEND = ST_SEND,
    FIN  = ST_FIN
  } state_t;

  localparam logic [3:0] PATT_1011 = 4'b1011;

`ifdef PATT_GEN_PARITY_EN
  localparam int unsigned PAR_BITS = 1;
`else
  localparam int unsigned PAR_BITS = 0;
`endif

  // Even parity over a zero-extended value: zero padding does not change the XOR.
  function automatic logic even_parity(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/patt_gen_if.sv
// patt_gen_if: request/serial-output bundle of the pattern transmitter.
//   start, patt[W-1:0], reps[CNT_W-1:0] : request side (driven by master)
//   x, vld, busy, done                  : transmitter side (driven by slave)
// Modports: master (requester / bench), slave (patt_gen).
interface patt_gen_if #(
  parameter int W     = 4,
  parameter int CNT_W = 4
) ();

  logic             start;
  logic [W-1:0]     patt;
  logic [CNT_W-1:0] reps;
  logic             x;
  logic             vld;
  logic             busy;
  logic             done;

  modport master (
    output start, patt, reps,
    input  x, vld, busy, done
  );

  modport slave (
    input  start, patt, reps,
    output x, vld, busy, done
  );

endinterface

// File: rtl/patt_shreg.sv
// patt_shreg: W-bit parallel-load, shift-left register; msb is the bit on the wire.
// Ports:
//   clk    in  clock
//   rst_b  in  asynchronous active-low reset (clears register)
//   load   in  load din (has priority over shift)
//   shift  in  shift left by one, zero filled
//   din    in  parallel load value [W-1:0]
//   msb    out register bit W-1
module patt_shreg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] q_r;

  // Shift register: load wins over shift, otherwise hold.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      q_r <= {W{1'b0}};
    end else if (load) begin
      q_r <= din;
    end else if (shift) begin
      q_r <= {q_r[W-2:0], 1'b0};
    end else begin
      q_r <= q_r;
    end
  end

  assign msb = q_r[W-1];

endmodule

// File: rtl/patt_gen.sv
// patt_gen: serial pattern transmitter.
//   On an accepted start (IDLE only) latches patt/reps and sends the pattern MSB-first
//   on x, one bit per clock, reps times back-to-back, then pulses done for one cycle.
// Ports:
//   clk    in  clock
//   rst_b  in  asynchronous active-low reset; aborts any transmission
//   bus    patt_gen_if.slave: start/patt/reps in, x/vld/busy/done out
// Configuration:
//   `PATT_GEN_PARITY_EN : append an even-parity bit (^patt) after patt[0] of every repetition.
// Note: x is taken straight from the shift register msb. The register is zero in IDLE and
// FIN (cleared by reset, shifted empty by the final bit, never loaded when reps==0), so x
// is a flop output that is already 0 whenever vld is low.
module patt_gen
  import patt_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst_b,
  patt_gen_if.slave  bus
);

  localparam int IDX_W = $clog2(W + 1);
  localparam int LAST  = W - 1 + int'(PAR_BITS);

  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LAST);
`ifdef PATT_GEN_PARITY_EN
  localparam logic [IDX_W-1:0] IDX_PAR  = IDX_W'(W - 1);
`endif
  localparam logic [CNT_W-1:0] REP_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] REP_ONE  = CNT_W'(1);

  state_t           state_r, state_n;
  logic [W-1:0]     patt_r, patt_n;
  logic [CNT_W-1:0] rep_r, rep_n;
  logic [IDX_W-1:0] idx_r, idx_n;
  logic             sh_load, sh_shift;
  logic [W-1:0]     sh_din;
  logic             sh_msb;
  logic             vld_r, busy_r, done_r;

  patt_shreg #(.W(W)) u_shreg (
    .clk   (clk),
    .rst_b (rst_b),
    .load  (sh_load),
    .shift (sh_shift),
    .din   (sh_din),
    .msb   (sh_msb)
  );

  // Next-state, counter and shift-register control.
  always_comb begin
    state_n  = state_r;
    patt_n   = patt_r;
    rep_n    = rep_r;
    idx_n    = idx_r;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    sh_din   = patt_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          patt_n = bus.patt;
          rep_n  = bus.reps;
          idx_n  = IDX_ZERO;
          if (bus.reps != REP_ZERO) begin
            // Load straight from the port so patt[W-1] is on x the very next cycle.
            state_n = SEND;
            sh_load = 1'b1;
            sh_din  = bus.patt;
          end else begin
            state_n = FIN;
          end
        end else begin
          state_n = IDLE;
        end
      end
      SEND: begin
        if (idx_r == IDX_LAST) begin
          rep_n = rep_r - REP_ONE;
          idx_n = IDX_ZERO;
          if (rep_r == REP_ONE) begin
            // Final bit: shifting empties the register so x returns to 0.
            state_n  = FIN;
            sh_shift = 1'b1;
          end else begin
            // Reload for the next repetition with no idle gap.
            sh_load = 1'b1;
            sh_din  = patt_r;
          end
        end
`ifdef PATT_GEN_PARITY_EN
        else if (idx_r == IDX_PAR) begin
          // Put the parity bit in the msb slot; the trailing zeros keep x clean afterwards.
          idx_n   = idx_r + IDX_ONE;
          sh_load = 1'b1;
          sh_din  = {even_parity(32'(patt_r)), {(W-1){1'b0}}};
        end
`endif
        else begin
          idx_n    = idx_r + IDX_ONE;
          sh_shift = 1'b1;
        end
      end
      FIN: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, latched request and counters.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r <= IDLE;
      patt_r  <= {W{1'b0}};
      rep_r   <= REP_ZERO;
      idx_r   <= IDX_ZERO;
    end else begin
      state_r <= state_n;
      patt_r  <= patt_n;
      rep_r   <= rep_n;
      idx_r   <= idx_n;
    end
  end

  // Framing outputs registered from the next state so they line up with x.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      vld_r  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      vld_r  <= (state_n == SEND);
      busy_r <= (state_n != IDLE);
      done_r <= (state_n == FIN);
    end
  end

  assign bus.x    = sh_msb;
  assign bus.vld  = vld_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_patt_gen.sv
// tb_patt_gen: directed bench for patt_gen (W=4, CNT_W=4).
// Outputs are sampled on the falling edge; inputs change on the falling edge or
// 1 time unit after a rising edge. Honours `PATT_GEN_PARITY_EN.
module tb_patt_gen;

`ifdef PATT_GEN_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk;
  logic rst_b;
  int   checks;
  int   errors;
  int   hits;
  int   done_cnt;
  logic [3:0] hist;

  patt_gen_if #(.W(4), .CNT_W(4)) bus ();

  patt_gen #(.W(4), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference 1011 detector (overlapping) fed by valid bits, plus a done-pulse counter.
  initial begin
    hist     = 4'b0000;
    hits     = 0;
    done_cnt = 0;
    forever begin
      @(negedge clk);
      if (bus.vld === 1'b1) begin
        hist = {hist[2:0], bus.x};
        if (hist == 4'b1011) hits++;
      end
      if (bus.done === 1'b1) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare {x, vld, busy, done}.
  task automatic chk_out(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, bus.x, bus.vld, bus.busy, bus.done}, {28'd0, exp});
  endtask

  // Issue a one-cycle start at the current falling edge.
  task automatic req(input logic [3:0] p, input logic [3:0] r);
    bus.start = 1'b1;
    bus.patt  = p;
    bus.reps  = r;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Expect n back-to-back valid bits (bits[n-1] first), then FIN, then IDLE.
  task automatic expect_stream(input string tag, input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_out(tag, {bits[n-1-i], 1'b1, 1'b1, 1'b0});
    end
    @(negedge clk);
    chk_out({tag, "_fin"}, 4'b0011);
    @(negedge clk);
    chk_out({tag, "_idle"}, 4'b0000);
  endtask

  initial begin
    int d0, h0, vcount, cyc;
    logic seen;
    logic [3:0] p1011;
    checks = 0;
    errors = 0;
    p1011 = patt_pkg::PATT_1011;
    rst_b = 1'b0;
    bus.start = 1'b0;
    bus.patt  = 4'b0000;
    bus.reps  = 4'b0000;

    // 1. reset state and idle with no start
    #10 chk_out("reset", 4'b0000);
    #15 rst_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_out("idle_no_start", 4'b0000);
    end

    // 2. single repetition of 1011
    req(p1011, 4'd1);
`ifdef PATT_GEN_PARITY_EN
    expect_stream("single_1011", 32'b10111, 5);
`else
    expect_stream("single_1011", 32'b1011, 4);
`endif

    // 3. three repetitions into the 1011 detector model
    d0 = done_cnt;
    h0 = hits;
    req(p1011, 4'd3);
`ifdef PATT_GEN_PARITY_EN
    expect_stream("rep3_1011", 32'b101111011110111, 15);
`else
    expect_stream("rep3_1011", 32'b101110111011, 12);
`endif
    chk("rep3_detector_hits", 32'(hits - h0), 32'd3);
    chk("rep3_done_once", 32'(done_cnt - d0), 32'd1);

    // other patterns: leading zero, and odd-weight pattern repeated
    req(4'b0110, 4'd1);
`ifdef PATT_GEN_PARITY_EN
    expect_stream("single_0110", 32'b01100, 5);
`else
    expect_stream("single_0110", 32'b0110, 4);
`endif
    req(4'b1110, 4'd2);
`ifdef PATT_GEN_PARITY_EN
    expect_stream("rep2_1110", 32'b1110111101, 10);
`else
    expect_stream("rep2_1110", 32'b11101110, 8);
`endif

    // 4. reps == 0: straight to FIN, no valid bits
    req(p1011, 4'd0);
    @(negedge clk);
    chk_out("reps0_fin", 4'b0011);
    @(negedge clk);
    chk_out("reps0_idle", 4'b0000);

    // 5a. start re-pulsed while busy with a different request is ignored
    d0 = done_cnt;
    bus.start = 1'b1;
    bus.patt  = p1011;
    bus.reps  = 4'd1;
    @(posedge clk);
    #1;
    bus.patt = 4'b0000;
    bus.reps = 4'd5;
    for (int i = 0; i < 4 + P; i++) begin
      @(negedge clk);
      chk_out("busy_ignore_bits", {p1011[3 - (i % 4)] | (i == 4 ? 1'b1 : 1'b0), 1'b1, 1'b1, 1'b0});
    end
    @(negedge clk);
    chk_out("busy_ignore_fin", 4'b0011);
    // start still high across the edge leaving FIN: must not be taken there
    @(negedge clk);
    chk_out("fin_exit_no_accept", 4'b0000);
    bus.start = 1'b0;
    @(negedge clk);
    chk_out("turnaround_idle", 4'b0000);
    chk("busy_ignore_done_once", 32'(done_cnt - d0), 32'd1);

    // 5b. asynchronous reset after bit 2 aborts with no done
    req(p1011, 4'd2);
    @(negedge clk);
    chk_out("abort_bit1", 4'b1110);
    @(negedge clk);
    chk_out("abort_bit2", 4'b0110);
    d0 = done_cnt;
    #2 rst_b = 1'b0;
    #1 chk_out("abort_async", 4'b0000);
    @(negedge clk);
    chk_out("abort_held", 4'b0000);
    #2 rst_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_out("abort_after", 4'b0000);
    end
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

    // 6. two repetitions of 1011 (parity stream when enabled)
    req(p1011, 4'd2);
`ifdef PATT_GEN_PARITY_EN
    expect_stream("rep2_1011", 32'b1011110111, 10);
`else
    expect_stream("rep2_1011", 32'b10111011, 8);
`endif

    // maximum repetition count transmits fully (bounded wait for done)
    req(4'b0110, 4'd15);
    vcount = 0;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.vld === 1'b1) vcount++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    chk("max_reps_done_seen", {31'd0, seen}, 32'd1);
    chk("max_reps_vld_count", 32'(vcount), 32'(15 * (4 + P)));
    chk("max_reps_done_latency", 32'(cyc), 32'(15 * (4 + P) + 1));
    @(negedge clk);
    chk_out("max_reps_idle", 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
